// File: rtl/hex_scan_scheduler.sv
// hex_scan_scheduler: two-port arbiter and refresh controller for a 4-digit
// hex display. A grant changes only on a frame boundary. The granted value
// is copied into a shadow register at that boundary, so a frame cannot show
// a mix of old and new digits. Each digit phase starts with a few blanked
// cycles to stop ghosting between digits.
module hex_scan_scheduler #(
    parameter int DIV   = 4,
    parameter int BLANK = 1,
    parameter int HOLD  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic [1:0]  grant,
    output logic [3:0]  anodes,
    output logic [3:0]  digit_data,
    output logic        frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HW = $clog2(HOLD + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);
    localparam logic [CW-1:0] BLANK_C  = CW'(BLANK);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t        state, state_n;
    logic [15:0]   shadow, shadow_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    dig, dig_n;
    logic [HW-1:0] hold, hold_n, hold_inc;
    logic          last, last_n;   // port index of the most recent winner
    logic [1:0]    grant_n;
    logic          fd_n;
    logic          win, cur, other, frame_end;
    logic [3:0]    anodes_n, digit_n;

    assign cur       = grant[1];
    assign other     = ~grant[1];
    assign frame_end = (state == SCAN) && (cnt == CNT_MAX) && (dig == 2'd3);
    assign hold_inc  = (hold == HOLD_MAX) ? hold : hold + HW'(1);

    // Next-state logic: arbitration at frame boundaries, scan counters otherwise
    always_comb begin
        state_n  = state;
        grant_n  = grant;
        shadow_n = shadow;
        cnt_n    = cnt;
        dig_n    = dig;
        hold_n   = hold;
        last_n   = last;
        fd_n     = 1'b0;
        // Round robin: the port that did not win last time has priority
        win      = req[~last] ? ~last : last;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    state_n  = SCAN;
                    grant_n  = 2'b01 << win;
                    last_n   = win;
                    shadow_n = win ? data1 : data0;
                    cnt_n    = '0;
                    dig_n    = 2'd0;
                    hold_n   = '0;
                end
            end
            SCAN: begin
                if (frame_end) begin
                    fd_n  = 1'b1;
                    cnt_n = '0;
                    dig_n = 2'd0;
                    if (req[cur] && (hold_inc < HOLD_MAX || !req[other])) begin
                        hold_n   = hold_inc;
                        shadow_n = cur ? data1 : data0;
                    end else if (req[other]) begin
                        grant_n  = 2'b01 << other;
                        last_n   = other;
                        hold_n   = '0;
                        shadow_n = other ? data1 : data0;
                    end else begin
                        // Nobody is asking: go idle and keep the shadow
                        state_n = IDLE;
                        grant_n = 2'b00;
                        hold_n  = hold_inc;
                    end
                end else if (cnt == CNT_MAX) begin
                    cnt_n = '0;
                    dig_n = dig + 2'd1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The display outputs come from next-state values. That keeps the
    // registered anodes and digit in line with the cnt/dig they belong to.
    always_comb begin
        anodes_n = 4'b0000;
        if (state_n == SCAN && cnt_n >= BLANK_C)
            anodes_n = 4'b0001 << dig_n;
        digit_n = shadow_n[{dig_n, 2'b00} +: 4];
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shadow     <= '0;
            cnt        <= '0;
            dig        <= 2'd0;
            hold       <= '0;
            last       <= 1'b1;
            grant      <= 2'b00;
            anodes     <= 4'b0000;
            digit_data <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            shadow     <= shadow_n;
            cnt        <= cnt_n;
            dig        <= dig_n;
            hold       <= hold_n;
            last       <= last_n;
            grant      <= grant_n;
            anodes     <= anodes_n;
            digit_data <= digit_n;
            frame_done <= fd_n;
        end
    end

endmodule

// File: tb/tb_hex_scan_scheduler.sv
// Directed bench for hex_scan_scheduler (DIV=4, BLANK=1, HOLD=2).
// A per-cycle vector table drives the single-port scan, the tear-free update
// and the release case. Hand-written sequences drive arbitration and the
// asynchronous reset.
module tb_hex_scan_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [15:0] data0 = 16'h0000;
    logic [15:0] data1 = 16'h0000;
    logic [1:0]  grant;
    logic [3:0]  anodes;
    logic [3:0]  digit_data;
    logic        frame_done;

    int total = 0;
    int passed = 0;

    hex_scan_scheduler #(.DIV(4), .BLANK(1), .HOLD(2)) dut (
        .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1),
        .grant(grant), .anodes(anodes), .digit_data(digit_data),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  req;
        logic [15:0] d0;
        logic [1:0]  g;
        logic [3:0]  an;
        logic [3:0]  dd;
        logic        fd;
        bit          ddc;
    } vec_t;

    vec_t tv[$];

    function automatic void add(logic [1:0] r, logic [15:0] d0, logic [1:0] g,
                                logic [3:0] an, logic [3:0] dd, logic fd, bit ddc);
        vec_t v;
        v.req = r; v.d0 = d0; v.g = g; v.an = an; v.dd = dd; v.fd = fd; v.ddc = ddc;
        tv.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Output bundle as {grant, anodes, digit_data, frame_done}
    function automatic logic [31:0] outs();
        return {21'd0, grant, anodes, digit_data, frame_done};
    endfunction

    function automatic logic [31:0] pack(logic [1:0] g, logic [3:0] an, logic [3:0] dd, logic fd);
        return {21'd0, g, an, dd, fd};
    endfunction

    logic [3:0] old_dig [4] = '{4'hC, 4'h2, 4'hA, 4'h3};
    logic [3:0] an_on   [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [1:0] arb_g   [4] = '{2'b01, 2'b10, 2'b10, 2'b01};
    logic [3:0] arb_dd  [4] = '{4'h3, 4'h7, 4'h7, 4'h3};

    initial begin
        // Frame 1: single port 0, data 3A2C, starting from IDLE
        for (int k = 0; k < 16; k++)
            add(2'b01, 16'h3A2C, 2'b01, (k % 4 == 0) ? 4'b0 : an_on[k/4], old_dig[k/4], 1'b0, 1);
        // Frame 2: data changes to FFFF at cycle 6 and must stay hidden
        for (int k = 0; k < 16; k++)
            add(2'b01, (k < 6) ? 16'h3A2C : 16'hFFFF, 2'b01,
                (k % 4 == 0) ? 4'b0 : an_on[k/4], old_dig[k/4], (k == 0), 1);
        // Frame 3: FFFF is shown, and req drops during digit 1
        for (int k = 0; k < 16; k++)
            add((k < 4) ? 2'b01 : 2'b00, 16'hFFFF, 2'b01,
                (k % 4 == 0) ? 4'b0 : an_on[k/4], 4'hF, (k == 0), 1);
        // Then IDLE: one frame_done pulse, no grant, dark display
        add(2'b00, 16'hFFFF, 2'b00, 4'b0, 4'h0, 1'b1, 0);
        for (int k = 0; k < 3; k++)
            add(2'b00, 16'hFFFF, 2'b00, 4'b0, 4'h0, 1'b0, 0);

        // Reset state
        #1;
        chk("reset_outputs", outs(), 32'd0);
        #12 rst = 1'b0;
        step();
        chk("idle_after_reset", outs(), 32'd0);

        // Table-driven vectors
        foreach (tv[i]) begin
            req = tv[i].req;
            data0 = tv[i].d0;
            step();
            if (tv[i].ddc)
                chk($sformatf("vec%0d", i), outs(), pack(tv[i].g, tv[i].an, tv[i].dd, tv[i].fd));
            else
                chk($sformatf("vec%0d", i), outs() & 32'h1E1,
                    pack(tv[i].g, tv[i].an, 4'h0, tv[i].fd));
        end

        // Arbitration: after reset both ports request in the same IDLE cycle
        rst = 1'b1;
        #2 rst = 1'b0;
        data0 = 16'h0123;
        data1 = 16'h4567;
        req = 2'b11;
        step();
        chk("arb_first_grant", outs(), pack(2'b01, 4'b0, 4'h3, 1'b0));
        for (int f = 0; f < 4; f++) begin
            repeat (15) step();
            chk($sformatf("arb_pre_boundary%0d", f), {30'd0, grant} | {31'd0, frame_done} << 8,
                {30'd0, (f == 0) ? 2'b01 : arb_g[f-1]});
            step();
            chk($sformatf("arb_boundary%0d", f), outs(), pack(arb_g[f], 4'b0, arb_dd[f], 1'b1));
        end

        // Asynchronous reset while digit 2 is lit
        repeat (9) step();
        chk("pre_reset_anodes", {28'd0, anodes}, 32'h4);
        #3 rst = 1'b1;
        #1;
        chk("async_reset_clear", outs(), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 2'b00;
        for (int k = 0; k < 20; k++) begin
            step();
            chk($sformatf("idle_hold%0d", k), outs() & 32'h1E1, 32'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
